// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one request in flight, fixed response latency,
// store byte-lane steering, load sign/zero extension, and range/alignment/funct3 checks.
module dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h80000000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] word_off;
  logic [IW-1:0] idx;
  logic [1:0]  lane;
  logic [31:0] cur;
  logic [31:0] shifted;
  logic        f3_ok;
  logic        misal;
  logic        in_range;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wfill;
  logic [31:0] ldata;
  logic        access;

  // reset_n is active-high here; the core drives it that way
  assign req_ready = (state == IDLE) && !reset_n;
  assign access    = (state == BUSY) && (cnt == 4'd0);
  assign word_off  = (addr_q - ADDR_BASE) >> 2;
  assign idx       = word_off[IW-1:0];
  assign lane      = addr_q[1:0];
  assign cur       = mem[idx];
  assign shifted   = cur >> {lane, 3'b000};

  always_comb begin
    if (we_q)
      f3_ok = !f3_q[2] && (f3_q[1:0] != 2'b11);
    else
      f3_ok = (f3_q[1:0] != 2'b11) && !(f3_q[2] && f3_q[1]);
    misal    = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
               ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    in_range = (addr_q >= ADDR_BASE) && (word_off < 32'(DEPTH_WORDS));
    err      = !f3_ok || misal || !in_range;
  end

  always_comb begin
    ldata = 32'd0;
    be    = 4'b1111;
    wfill = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        ldata = f3_q[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        be    = 4'b0001 << lane;
        wfill = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        ldata = f3_q[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wfill = {2{wdata_q[15:0]}};
      end
      2'b10: ldata = cur;
      default: ldata = 32'd0;
    endcase
  end

  // Array is never cleared; a reset coinciding with the access edge suppresses the write
  always_ff @(posedge clk) begin
    if (!reset_n && access && we_q && !err)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wfill[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          cnt     <= 4'(LATENCY - 1);
          state   <= BUSY;
        end
        BUSY: if (cnt == 4'd0) begin
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (err || we_q) ? 32'd0 : ldata;
          state     <= RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a
// byte-level reference model of a 16-word window of the array.
module tb_dmem_responder;
  localparam logic [31:0] BASE  = 32'h80000000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] mw [16];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  // Drive one request, measure accept->rsp_valid latency, hold rsp_ready low 'hold' cycles.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    rd = rsp_rdata; e = rsp_err;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Reference: byte-addressed memory semantics over the model window.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic e);
    longint off;
    int sz, w, lane;
    logic [31:0] v, m;
    off = longint'(a) - longint'(BASE);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e = (off < 0) || (off >= 4 * DEPTH) || ((a % sz) != 0) ||
        (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5));
    rd = 32'd0;
    if (e) return;
    w = int'(off / 4);
    lane = int'(off % 4);
    if (we) begin
      for (int k = 0; k < sz; k++) mw[w][8*(lane+k) +: 8] = wd[8*k +: 8];
    end else begin
      v = mw[w] >> (8 * lane);
      if (sz < 4) begin
        m = (32'd1 << (8 * sz)) - 32'd1;
        v = v & m;
        if (!f3[2] && v[8*sz-1]) v = v | ~m;
      end
      rd = v;
    end
  endfunction

  task automatic test_reset();
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, want 0 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 3'b010, 32'h80000010, 32'hDEADBEEF, 0, rd, e, lat);
    checks++;
    if (lat !== LAT || e !== 1'b0 || rd !== 32'd0) begin
      errors++; $display("FAIL basic_sw: lat=%0d err=%b rdata=%h, want %0d 0 00000000", lat, e, rd, LAT);
    end
    xact(1'b0, 3'b010, 32'h80000010, 32'h0, 0, rd, e, lat);
    checks++;
    if (lat !== LAT || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_lw: lat=%0d err=%b rdata=%h, want %0d 0 deadbeef", lat, e, rd, LAT);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] rd; logic e; int lat;
    logic [2:0]  f3s [8] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001, 3'b100, 3'b000};
    logic [1:0]  offs[8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd1, 2'd3};
    logic [31:0] exps[8] = '{32'h0000007F, 32'h0000007F, 32'hFFFFFFF0, 32'hFFFFF07F,
                             32'h00008001, 32'hFFFF8001, 32'h000000F0, 32'hFFFFFF80};
    xact(1'b1, 3'b010, 32'h80000020, 32'h8001F07F, 0, rd, e, lat);
    for (int i = 0; i < 8; i++) begin
      xact(1'b0, f3s[i], 32'h80000020 + 32'(offs[i]), 32'h0, 0, rd, e, lat);
      checks++;
      if (rd !== exps[i] || e !== 1'b0) begin
        errors++; $display("FAIL load_ext[%0d]: rdata=%h err=%b, want %h 0", i, rd, e, exps[i]);
      end
    end
  endtask

  task automatic test_store_lanes();
    logic [31:0] rd; logic e; int lat;
    logic [2:0]  f3s [4] = '{3'b000, 3'b001, 3'b000, 3'b001};
    logic [1:0]  offs[4] = '{2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] wds [4] = '{32'h000000AA, 32'h0000BEEF, 32'h12345655, 32'hFFFF1234};
    logic [31:0] exps[4] = '{32'hAA223344, 32'hBEEF3344, 32'hBEEF3355, 32'hBEEF1234};
    xact(1'b1, 3'b010, 32'h80000030, 32'h11223344, 0, rd, e, lat);
    for (int i = 0; i < 4; i++) begin
      xact(1'b1, f3s[i], 32'h80000030 + 32'(offs[i]), wds[i], 0, rd, e, lat);
      xact(1'b0, 3'b010, 32'h80000030, 32'h0, 0, rd, e, lat);
      checks++;
      if (rd !== exps[i] || e !== 1'b0) begin
        errors++; $display("FAIL store_lane[%0d]: word=%h err=%b, want %h 0", i, rd, e, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    logic        wes [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0]  f3s [9] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b011, 3'b011, 3'b100, 3'b001, 3'b010};
    logic [31:0] adrs[9] = '{32'h80000001, 32'h80000002, 32'h7FFFFFFC, 32'h80001000, 32'h80000000,
                             32'h80000000, 32'h80000000, 32'h80000FFF, 32'h80001000};
    xact(1'b1, 3'b010, 32'h80000000, 32'hA5A5A5A5, 0, rd, e, lat);
    xact(1'b1, 3'b010, 32'h80000FFC, 32'h5A5A5A5A, 0, rd, e, lat);
    checks++;
    if (e !== 1'b0) begin
      errors++; $display("FAIL last_word_in_range: err=%b want 0", e);
    end
    for (int i = 0; i < 9; i++) begin
      xact(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, 0, rd, e, lat);
      checks++;
      if (e !== 1'b1 || rd !== 32'd0) begin
        errors++; $display("FAIL err_case[%0d]: err=%b rdata=%h, want 1 00000000", i, e, rd);
      end
    end
    xact(1'b0, 3'b010, 32'h80000000, 32'h0, 0, rd, e, lat);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL err_no_write_w0: got %h want a5a5a5a5", rd);
    end
    xact(1'b0, 3'b010, 32'h80000FFC, 32'h0, 0, rd, e, lat);
    checks++;
    if (rd !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL err_no_write_last: got %h want 5a5a5a5a", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic e; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80000010;
    lat = 0;
    while (!req_ready && lat < 50) begin @(negedge clk); lat++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b rdata=%h err=%b ready=%b, want 1 deadbeef 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      req_valid = i[0]; req_we = 1'b1; req_funct3 = 3'b010; req_wdata = 32'h0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL after_handshake: ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
    end
    xact(1'b0, 3'b010, 32'h80000010, 32'h0, 0, rd, e, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL busy_req_ignored: word=%h want deadbeef", rd);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic e; int lat;
    bit seen;
    xact(1'b1, 3'b010, 32'h80000040, 32'h0, 0, rd, e, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h80000040; req_wdata = 32'h12345678;
    lat = 0;
    while (!req_ready && lat < 50) begin @(negedge clk); lat++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    seen = rsp_valid;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_ready: got %b want 1", req_ready);
    end
    for (int i = 0; i < 6; i++) begin
      seen |= rsp_valid;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_rsp: rsp_valid rose=%b want 0", seen);
    end
    xact(1'b0, 3'b010, 32'h80000040, 32'h0, 0, rd, e, lat);
    checks++;
    if (rd !== 32'd0 || e !== 1'b0) begin
      errors++; $display("FAIL abort_no_write: word=%h err=%b want 00000000 0", rd, e);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd; logic e, exp_e; int lat;
    logic [31:0] oor [4] = '{32'h7FFFFFFC, 32'h00000000, 32'h80001000, 32'hFFFFFFFC};
    logic we; logic [2:0] f3; logic [31:0] a, wd;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model(1'b1, 3'b010, BASE + 32'(4 * i), wd, exp_rd, exp_e);
      xact(1'b1, 3'b010, BASE + 32'(4 * i), wd, 0, rd, e, lat);
    end
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) a = oor[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
      else a = BASE + 32'($urandom_range(0, 63));
      model(we, f3, a, wd, exp_rd, exp_e);
      xact(we, f3, a, wd, $urandom_range(0, 2), rd, e, lat);
      checks++;
      if (rd !== exp_rd || e !== exp_e || lat !== LAT) begin
        errors++;
        $display("FAIL rand[%0d] we=%b f3=%0d addr=%h wd=%h: rdata=%h err=%b lat=%0d, want %h %b %0d",
                 i, we, f3, a, wd, rd, e, lat, exp_rd, exp_e, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_ext();
    test_store_lanes();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
